header_parser: RTL and testbench

Single-stage pass-through parser on the 64-bit packet-processing datapath. Packets flow unmodified, with one-cycle latency, from the upstream `in_*` bus to the downstream `out_*` bus. Along the way the block parses Ethernet/IPv4/UDP headers and flags which output words carry UDP payload. It also reports a per-packet payload word count for downstream accelerators.

---
 rtl/header_parser.sv | 112 +++++++++++
 tb/tb_header_parser.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/header_parser.sv
// One-cycle pass-through on the 64-bit packet bus that parses Ethernet/IPv4/UDP
// headers, flags UDP payload words on the output and counts them per packet.
module header_parser #(
  parameter int DWIDTH     = 64,
  parameter int CTRL_WIDTH = DWIDTH / 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic [DWIDTH-1:0]     in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DWIDTH-1:0]     out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [15:0]           data_count,
  output logic                  o_inside_payload
);

  typedef enum logic {S_MODHDR, S_BODY} state_e;

  state_e                  state_q, state_d;
  logic [7:0]              idx_q, idx_d;
  logic [15:0]             count_q, count_d;
  logic [15:0]             ethertype_q;
  logic [3:0]              ihl_q;
  logic [7:0]              proto_q;
  logic [DWIDTH-1:0]       out_data_q;
  logic [CTRL_WIDTH-1:0]   out_ctrl_q;
  logic                    out_wr_q;
  logic                    payload_q, payload_d;

  logic                    accept;
  logic                    ctrl_zero;
  logic                    first_word;
  logic                    body_word;
  logic [7:0]              pw;

  assign in_rdy = out_rdy;

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    accept     = in_wr & out_rdy;
    ctrl_zero  = (in_ctrl == '0);
    first_word = (state_q == S_MODHDR) & ctrl_zero;
    body_word  = (state_q == S_BODY) | ctrl_zero;

    idx_d = idx_q;
    if (first_word)          idx_d = 8'd0;
    else if (idx_q != 8'hFF) idx_d = idx_q + 8'd1;

    // First payload word = (14 + 4*IHL + 8) >> 3, using the fields latched earlier.
    pw = (8'd22 + {2'b00, ihl_q, 2'b00}) >> 3;

    payload_d = body_word & (ethertype_q == 16'h0800) & (proto_q == 8'd17) &
                (ihl_q >= 4'd5) & (idx_d >= pw);

    state_d = state_q;
    if (first_word)                          state_d = S_BODY;
    else if (state_q == S_BODY && !ctrl_zero) state_d = S_MODHDR;

    count_d = count_q;
    if (first_word)                               count_d = 16'd0;
    else if (payload_d && count_q != 16'hFFFF)    count_d = count_q + 16'd1;
  end

  // NOTE: state uses non-blocking assignments; the datapath copy is reset too so
  // out_data/out_ctrl read as zero straight after reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q     <= S_MODHDR;
      idx_q       <= '0;
      count_q     <= '0;
      ethertype_q <= '0;
      ihl_q       <= '0;
      proto_q     <= '0;
      out_data_q  <= '0;
      out_ctrl_q  <= '0;
      out_wr_q    <= 1'b0;
      payload_q   <= 1'b0;
    end else begin
      out_data_q <= in_data;
      out_ctrl_q <= in_ctrl;
      out_wr_q   <= accept;
      payload_q  <= accept & payload_d;
      if (accept) begin
        state_q <= state_d;
        count_q <= count_d;
        if (body_word) idx_q <= idx_d;
        if (first_word) begin
          ethertype_q <= '0;
          ihl_q       <= '0;
          proto_q     <= '0;
        end else if (state_q == S_BODY) begin
          if (idx_d == 8'd1) begin
            ethertype_q <= in_data[31:16];
            ihl_q       <= in_data[11:8];
          end
          if (idx_d == 8'd2) proto_q <= in_data[7:0];
        end
      end
    end
  end

  assign out_data         = out_data_q;
  assign out_ctrl         = out_ctrl_q;
  assign out_wr           = out_wr_q;
  assign o_inside_payload = payload_q;
  assign data_count       = count_q;

endmodule

// File: tb/tb_header_parser.sv
// Randomised bench for header_parser: a packet-level reference model pushes the
// expected output words into a scoreboard that a negedge monitor drains.
module tb_header_parser;

  logic        i_clock;
  logic        i_reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic [15:0] data_count;
  logic        o_inside_payload;

  header_parser #(.DWIDTH(64), .CTRL_WIDTH(8)) dut (
    .i_clock          (i_clock),
    .i_reset          (i_reset),
    .in_data          (in_data),
    .in_ctrl          (in_ctrl),
    .in_wr            (in_wr),
    .in_rdy           (in_rdy),
    .out_data         (out_data),
    .out_ctrl         (out_ctrl),
    .out_wr           (out_wr),
    .out_rdy          (out_rdy),
    .data_count       (data_count),
    .o_inside_payload (o_inside_payload)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  ctrl;
    logic        pay;
    logic [15:0] cnt;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] pkt[$];
  logic [15:0] exp_count;
  int          n_vec;
  int          n_err;
  bit          mon_en;
  bit          rnd_mode;
  logic        prev_rdy;

  initial begin
    i_clock = 1'b0;
    forever #5 i_clock = ~i_clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares every presented output word against the scoreboard head.
  always @(negedge i_clock) begin
    if (mon_en) begin
      check("in_rdy_eq_out_rdy", 64'(in_rdy), 64'(out_rdy));
      if (!prev_rdy) check("out_wr_after_rdy_low", 64'(out_wr), 64'(0));
      if (out_wr) begin
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_output: got data %h with empty scoreboard", out_data);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_data", out_data, e.data);
          check("out_ctrl", 64'(out_ctrl), 64'(e.ctrl));
          check("inside_payload", 64'(o_inside_payload), 64'(e.pay));
          check("data_count", 64'(data_count), 64'(e.cnt));
        end
      end else begin
        check("idle_payload_low", 64'(o_inside_payload), 64'(0));
      end
    end
    prev_rdy = out_rdy;
  end

  // Presents one word until accepted; the expected output is queued at acceptance.
  task automatic drive(input logic [63:0] d, input logic [7:0] c, input logic pay,
                       input logic [15:0] cnt);
    int  tries;
    bit  done;
    bit  go;
    exp_t e;
    tries = 0;
    done  = 0;
    while (!done) begin
      if (rnd_mode && tries < 8) begin
        out_rdy = 1'($urandom_range(0, 1));
        go      = out_rdy && ($urandom_range(0, 3) != 0);
      end else begin
        out_rdy = 1'b1;
        go      = 1'b1;
      end
      if (go) begin
        in_wr   = 1'b1;
        in_data = d;
        in_ctrl = c;
        e.data = d; e.ctrl = c; e.pay = pay; e.cnt = cnt;
        sb.push_back(e);
      end else begin
        in_wr   = 1'b0;
        in_data = {$urandom, $urandom};
        in_ctrl = 8'($urandom);
      end
      @(posedge i_clock);
      #1;
      in_wr = 1'b0;
      tries++;
      done = go;
    end
  endtask

  task automatic idle(input int n);
    in_wr   = 1'b0;
    out_rdy = 1'b1;
    repeat (n) begin
      @(posedge i_clock);
      #1;
    end
  endtask

  task automatic build(input int n, input logic [15:0] et, input logic [3:0] ihl,
                       input logic [7:0] proto);
    pkt.delete();
    for (int i = 0; i < n; i++) begin
      if (i == 1)      pkt.push_back({$urandom, et, 4'h4, ihl, 8'h00});
      else if (i == 2) pkt.push_back({$urandom, 24'($urandom), proto});
      else             pkt.push_back({$urandom, $urandom});
    end
  endtask

  // Reference model: payload = IPv4 && UDP && IHL>=5 && index >= (14+4*IHL+8)/8.
  task automatic send_packet(input int nhdr, input bit terminate, input logic [7:0] last_ctrl);
    int  n;
    bit  ipv4;
    bit  udp;
    int  ihl;
    int  pw;
    bit  pay;
    logic [7:0] c;
    for (int h = 0; h < nhdr; h++)
      drive({$urandom, $urandom}, 8'hFF, 1'b0, exp_count);
    n    = pkt.size();
    ipv4 = (n > 1) && (pkt[1][31:16] == 16'h0800);
    ihl  = (n > 1) ? int'(pkt[1][11:8]) : 0;
    udp  = (n > 2) && (pkt[2][7:0] == 8'd17);
    pw   = (14 + 4 * ihl + 8) / 8;
    for (int i = 0; i < n; i++) begin
      pay = ipv4 && udp && (ihl >= 5) && (i >= pw);
      c   = (terminate && i == n - 1) ? last_ctrl : 8'h00;
      if (i == 0)                          exp_count = 16'd0;
      else if (pay && exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
      drive(pkt[i], c, pay, exp_count);
    end
  endtask

  task automatic do_reset();
    in_wr   = 1'b0;
    i_reset = 1'b1;
    @(posedge i_clock);
    #1;
    i_reset   = 1'b0;
    exp_count = 16'd0;
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    mon_en    = 0;
    rnd_mode  = 0;
    prev_rdy  = 1'b1;
    exp_count = 16'd0;
    in_data   = '0;
    in_ctrl   = '0;
    in_wr     = 1'b0;
    out_rdy   = 1'b1;
    i_reset   = 1'b1;
    @(posedge i_clock);
    #1;
    i_reset = 1'b0;
    check("rst_out_wr", 64'(out_wr), 64'(0));
    check("rst_out_data", out_data, 64'(0));
    check("rst_out_ctrl", 64'(out_ctrl), 64'(0));
    check("rst_payload", 64'(o_inside_payload), 64'(0));
    check("rst_data_count", 64'(data_count), 64'(0));
    check("rst_in_rdy", 64'(in_rdy), 64'(out_rdy));
    mon_en = 1;

    // Directed packets at full rate.
    build(10, 16'h0800, 4'd5, 8'd17); send_packet(1, 1, 8'h80); idle(2);
    check("count_ihl5", 64'(data_count), 64'(5));
    build(10, 16'h0800, 4'd6, 8'd17); send_packet(1, 1, 8'h80); idle(2);
    check("count_ihl6", 64'(data_count), 64'(5));
    build(10, 16'h0800, 4'd8, 8'd17); send_packet(1, 1, 8'h80); idle(2);
    check("count_ihl8", 64'(data_count), 64'(4));
    build(10, 16'h0806, 4'd5, 8'd17); send_packet(1, 1, 8'h80); idle(2);
    check("count_arp", 64'(data_count), 64'(0));
    build(10, 16'h0800, 4'd5, 8'd6); send_packet(1, 1, 8'h80); idle(2);
    check("count_tcp", 64'(data_count), 64'(0));
    build(10, 16'h0800, 4'd4, 8'd17); send_packet(1, 1, 8'h80); idle(2);
    check("count_ihl4", 64'(data_count), 64'(0));
    build(3, 16'h0800, 4'd5, 8'd17); send_packet(0, 1, 8'h01); idle(2);
    build(300, 16'h0800, 4'd5, 8'd17); send_packet(2, 1, 8'h80); idle(2);
    check("count_long", 64'(data_count), 64'(295));

    // Back-to-back random packets with out_rdy toggling.
    rnd_mode = 1;
    for (int p = 0; p < 40; p++) begin
      logic [15:0] et;
      logic [7:0]  proto;
      et    = ($urandom_range(0, 3) != 0) ? 16'h0800 : 16'h86DD;
      proto = ($urandom_range(0, 3) != 0) ? 8'd17 : 8'd6;
      build($urandom_range(2, 16), et, 4'($urandom_range(3, 9)), proto);
      send_packet($urandom_range(0, 2), 1, 8'($urandom_range(1, 255)));
    end
    rnd_mode = 0;
    idle(3);
    check("sb_drained_random", 64'(sb.size()), 64'(0));

    // Reset after word 3 of a packet, then the leftover words, then a full packet.
    build(10, 16'h0800, 4'd5, 8'd17);
    begin
      logic [63:0] full[$];
      full = pkt;
      pkt.delete();
      for (int i = 0; i < 4; i++) pkt.push_back(full[i]);
      send_packet(1, 0, 8'h00);
      do_reset();
      check("midrst_out_wr", 64'(out_wr), 64'(0));
      check("midrst_data_count", 64'(data_count), 64'(0));
      check("midrst_sb_empty", 64'(sb.size()), 64'(0));
      pkt.delete();
      for (int i = 4; i < 10; i++) pkt.push_back(full[i]);
      send_packet(0, 1, 8'h80);
    end
    build(12, 16'h0800, 4'd5, 8'd17); send_packet(1, 1, 8'h80); idle(3);
    check("count_after_reset", 64'(data_count), 64'(7));
    check("sb_drained_final", 64'(sb.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
